// File: rtl/btn_debounce.sv
// btn_debounce: multi-channel push-button conditioner.
// Each channel: pin synchroniser -> polarity normalisation -> consecutive-sample
// bounce filter -> registered level plus press/release/long-press strobes.
// Channels share nothing but the clock and reset.

module btn_debounce #(
  parameter int                  CHANNELS      = 4,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  FILTER_CYCLES = 16,
  parameter int                  LONG_CYCLES   = 1000,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW    = {CHANNELS{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic [CHANNELS-1:0] long_held
);

  localparam int FW = $clog2(FILTER_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  // Filter counter value on which one more differing sample flips the level.
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  // Long-press counter saturation value.
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_CYCLES);

  // Synchroniser chain, stage 0 captures the raw pin.
  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] sample_s;

  // Per-channel counters, current and next.
  logic [FW-1:0] fcnt_r [CHANNELS];
  logic [FW-1:0] fcnt_s [CHANNELS];
  logic [LW-1:0] lcnt_r [CHANNELS];
  logic [LW-1:0] lcnt_s [CHANNELS];

  // Registered outputs and their next values.
  logic [CHANNELS-1:0] pressed_r, pressed_s;
  logic [CHANNELS-1:0] press_r,   press_s;
  logic [CHANNELS-1:0] rel_r,     rel_s;
  logic [CHANNELS-1:0] long_r,    long_s;
  logic [CHANNELS-1:0] held_r,    held_s;

  // Synchronise raw pins; reset parks every stage at the idle pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= ACTIVE_LOW;
      end
    end else begin
      sync_r[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // After normalisation a 1 always means "button pressed".
  assign sample_s = sync_r[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Next-state for bounce filter and long-press tracking, per channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      fcnt_s[i]    = fcnt_r[i];
      lcnt_s[i]    = lcnt_r[i];
      pressed_s[i] = pressed_r[i];
      press_s[i]   = 1'b0;
      rel_s[i]     = 1'b0;
      long_s[i]    = 1'b0;
      held_s[i]    = held_r[i];

      // Bounce filter: only an unbroken run of FILTER_CYCLES differing
      // samples is accepted; any agreeing sample restarts the run.
      if (sample_s[i] == pressed_r[i]) begin
        fcnt_s[i] = {FW{1'b0}};
      end else if (fcnt_r[i] == F_LAST) begin
        fcnt_s[i]    = {FW{1'b0}};
        pressed_s[i] = ~pressed_r[i];
        if (pressed_r[i]) begin
          rel_s[i] = 1'b1;
        end else begin
          press_s[i] = 1'b1;
        end
      end else begin
        fcnt_s[i] = fcnt_r[i] + FW'(1);
      end

      // Long press: count while pressed, saturate, fire once on arrival.
      // The release edge clears it together with the release strobe.
      if (!pressed_r[i] || rel_s[i]) begin
        lcnt_s[i] = {LW{1'b0}};
        held_s[i] = 1'b0;
      end else if (lcnt_r[i] != L_MAX) begin
        lcnt_s[i] = lcnt_r[i] + LW'(1);
        if (lcnt_s[i] == L_MAX) begin
          long_s[i] = 1'b1;
          held_s[i] = 1'b1;
        end else begin
          held_s[i] = 1'b0;
        end
      end else begin
        lcnt_s[i] = L_MAX;
        held_s[i] = 1'b1;
      end
    end
  end

  // Register counters and all outputs; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        fcnt_r[i] <= {FW{1'b0}};
        lcnt_r[i] <= {LW{1'b0}};
      end
      pressed_r <= {CHANNELS{1'b0}};
      press_r   <= {CHANNELS{1'b0}};
      rel_r     <= {CHANNELS{1'b0}};
      long_r    <= {CHANNELS{1'b0}};
      held_r    <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        fcnt_r[i] <= fcnt_s[i];
        lcnt_r[i] <= lcnt_s[i];
      end
      pressed_r <= pressed_s;
      press_r   <= press_s;
      rel_r     <= rel_s;
      long_r    <= long_s;
      held_r    <= held_s;
    end
  end

  assign pressed       = pressed_r;
  assign press_pulse   = press_r;
  assign release_pulse = rel_r;
  assign long_pulse    = long_r;
  assign long_held     = held_r;

endmodule
